bias_buffer_writer: RTL and testbench

//  Write side of the per-layer bias store used by the CNN engine.
//  - Accepts a stream of 8-bit bias bytes from the RISC-V SoC loader over a valid/ready handshake.
//  - Writes the bytes in order into a DEPTH-entry register-file buffer.
//  - Flags completion or error, and serves registered reads to the depthwise/pointwise compute stages.
//  - Replaces fixed bias ROMs, so biases can be reloaded per layer at runtime.

---
 rtl/bias_buffer_writer.sv | 133 +++++++++++++
 tb/tb_bias_buffer_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bias_buffer_writer.sv
// Per-layer bias store, write side: takes a bias byte stream over valid/ready,
// fills a register-file buffer in order, flags done/error, serves registered reads.
module bias_buffer_writer #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t state, state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic beat;
    logic at_end;
    logic clr;
    logic wr_en;
    logic finish;
    logic err_set;

    assign wr_ready = (state == LOAD);
    assign beat     = wr_valid & wr_ready;
    assign at_end   = (word_count == LAST_IDX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle control strobes; a restart outranks a same-cycle beat
    always_comb begin
        state_next = state;
        clr        = 1'b0;
        wr_en      = 1'b0;
        finish     = 1'b0;
        err_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_start) begin
                    state_next = LOAD;
                    clr        = 1'b1;
                end
            end
            LOAD: begin
                if (load_start) begin
                    clr = 1'b1;
                end else if (beat) begin
                    wr_en = 1'b1;
                    if (wr_last || at_end) begin
                        state_next = DONE;
                        finish     = 1'b1;
                        err_set    = wr_last ^ at_end;
                    end
                end
            end
            DONE: begin
                if (load_start) begin
                    state_next = LOAD;
                    clr        = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Byte counter and completion/error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (clr) begin
            word_count <= '0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (wr_en) begin
                word_count <= word_count + (ADDR_W+1)'(1);
            end
            if (finish) begin
                load_done <= 1'b1;
                load_err  <= err_set;
            end
        end
    end

    // Bias storage, cleared on reset, written in arrival order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[word_count[ADDR_W-1:0]] <= wr_data;
        end
    end

    // Registered read; sees the pre-write value on a same-entry collision
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_bias_buffer_writer.sv
// Directed bench for bias_buffer_writer: full, gapped, short, overlong,
// restart/collision and async-reset loads against hand-computed values.
module tb_bias_buffer_writer;

    logic       clk;
    logic       rst_n;
    logic       load_start;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       wr_last;
    logic       load_done;
    logic       load_err;
    logic [6:0] word_count;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    bias_buffer_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .wr_last    (wr_last),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = l;
        while (!wr_ready && n < 100) begin
            tick();
            n++;
        end
        if (!wr_ready) check("ready_timeout", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic rd(input string tag, input int a, input logic [7:0] exp);
        rd_addr = 6'(a);
        tick();
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst_n      = 1'b0;
        load_start = 1'b0;
        wr_valid   = 1'b0;
        wr_data    = 8'h00;
        wr_last    = 1'b0;
        rd_addr    = 6'd0;
        #12;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_wc", 32'(word_count), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle_ready", 32'(wr_ready), 32'd0);

        // T1 full load
        start();
        check("t1_ready", 32'(wr_ready), 32'd1);
        for (int i = 0; i < 64; i++) begin
            send(8'(i) ^ 8'hA5, i == 63);
        end
        check("t1_done", 32'(load_done), 32'd1);
        check("t1_err", 32'(load_err), 32'd0);
        check("t1_wc", 32'(word_count), 32'd64);
        check("t1_ready_off", 32'(wr_ready), 32'd0);
        for (int k = 0; k < 64; k++) begin
            rd("t1_mem", k, 8'(k) ^ 8'hA5);
        end

        // T2 same load with random gaps
        start();
        for (int i = 0; i < 64; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                wr_valid = 1'b0;
                tick();
                check("t2_wc_gap", 32'(word_count), 32'(i));
            end
            send(8'(i) ^ 8'hA5, i == 63);
        end
        check("t2_done", 32'(load_done), 32'd1);
        check("t2_err", 32'(load_err), 32'd0);
        check("t2_wc", 32'(word_count), 32'd64);
        for (int k = 0; k < 64; k += 7) begin
            rd("t2_mem", k, 8'(k) ^ 8'hA5);
        end

        // T3 short load
        start();
        check("t3_clr_done", 32'(load_done), 32'd0);
        for (int i = 0; i < 10; i++) begin
            send(8'h11, i == 9);
        end
        check("t3_done", 32'(load_done), 32'd1);
        check("t3_err", 32'(load_err), 32'd1);
        check("t3_wc", 32'(word_count), 32'd10);
        for (int k = 0; k < 10; k++) begin
            rd("t3_mem", k, 8'h11);
        end
        rd("t3_mem10", 10, 8'hAF);
        rd("t3_mem63", 63, 8'h9A);

        // T4 overlong: valid held high, no last
        start();
        check("t4_clr_err", 32'(load_err), 32'd0);
        wr_valid = 1'b1;
        wr_last  = 1'b0;
        for (int i = 0; i < 64; i++) begin
            wr_data = 8'(i) ^ 8'h3C;
            tick();
        end
        check("t4_done", 32'(load_done), 32'd1);
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_ready", 32'(wr_ready), 32'd0);
        check("t4_wc", 32'(word_count), 32'd64);
        wr_data = 8'hFF;
        tick();
        check("t4_wc_hold", 32'(word_count), 32'd64);
        wr_valid = 1'b0;
        rd("t4_mem63", 63, 8'h03);
        rd("t4_mem0", 0, 8'h3C);

        // T5 restart on beat 5, then read/write collision
        start();
        for (int i = 0; i < 5; i++) begin
            send(8'hC0 + 8'(i), 1'b0);
        end
        check("t5_wc5", 32'(word_count), 32'd5);
        wr_valid   = 1'b1;
        wr_data    = 8'hEE;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        wr_valid   = 1'b0;
        check("t5_wc_restart", 32'(word_count), 32'd0);
        check("t5_ready", 32'(wr_ready), 32'd1);
        rd("t5_mem5", 5, 8'h39);
        for (int i = 0; i < 3; i++) begin
            send(8'h20 + 8'(i), 1'b0);
        end
        rd_addr  = 6'd3;
        wr_valid = 1'b1;
        wr_data  = 8'h7F;
        tick();
        wr_valid = 1'b0;
        check("t5_coll_old", 32'(rd_data), 32'hC3);
        tick();
        check("t5_coll_new", 32'(rd_data), 32'h7F);
        check("t5_wc4", 32'(word_count), 32'd4);
        rd("t5_mem0", 0, 8'h20);

        // T6 async reset mid-load, between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_ready", 32'(wr_ready), 32'd0);
        check("t6_done", 32'(load_done), 32'd0);
        check("t6_wc", 32'(word_count), 32'd0);
        check("t6_rd", 32'(rd_data), 32'd0);
        rst_n = 1'b1;
        rd("t6_mem0", 0, 8'h00);
        rd("t6_mem3", 3, 8'h00);
        rd("t6_mem63", 63, 8'h00);
        check("t6_idle", 32'(wr_ready), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
